// File: rtl/falafel_frontend.sv
// Host-facing frontend for the falafel allocator core: buffers host alloc/free requests in
// FWFT FIFOs for the core, queues core responses back to the host, and tracks alloc credits.

package falafel_pkg;
    parameter int DATA_W = 32;
endpackage

module falafel_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_i,
    input  logic [W-1:0] din_i,
    input  logic         rd_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign dout_o  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_i && !full_o)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_i && !empty_o)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_i && !full_o)
            mem[wr_ptr[AW-1:0]] <= din_i;
    end
endmodule

module falafel_frontend #(
    parameter int DATA_W      = falafel_pkg::DATA_W,
    parameter int ALLOC_DEPTH = 4,
    parameter int FREE_DEPTH  = 4,
    parameter int RESP_DEPTH  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          host_req_val_i,
    output logic                          host_req_rdy_o,
    input  logic                          host_req_op_i,
    input  logic [DATA_W-1:0]             host_req_data_i,
    output logic                          host_rsp_val_o,
    input  logic                          host_rsp_rdy_i,
    output logic [DATA_W-1:0]             host_rsp_data_o,
    output logic                          alloc_fifo_empty_o,
    input  logic                          alloc_fifo_read_i,
    output logic [DATA_W-1:0]             alloc_fifo_dout_o,
    output logic                          free_fifo_empty_o,
    input  logic                          free_fifo_read_i,
    output logic [DATA_W-1:0]             free_fifo_dout_o,
    output logic                          resp_fifo_full_o,
    input  logic                          resp_fifo_write_i,
    input  logic [DATA_W-1:0]             resp_fifo_din_i,
    output logic [$clog2(RESP_DEPTH):0]   alloc_credits_o,
    output logic [1:0]                    err_o
);
    localparam int CW = $clog2(RESP_DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(RESP_DEPTH);
    localparam logic [CW-1:0] CREDIT_ONE = CW'(1);

    logic alloc_full;
    logic free_full;
    logic resp_empty;
    logic alloc_rdy;
    logic free_rdy;
    logic alloc_push;
    logic free_push;
    logic rsp_pop;

    // Ready looks only at registered state so a same-cycle core read never unblocks the host.
    assign alloc_rdy      = !alloc_full && (alloc_credits_o < CREDIT_MAX);
    assign free_rdy       = !free_full;
    assign host_req_rdy_o = host_req_op_i ? free_rdy : alloc_rdy;

    assign alloc_push = host_req_val_i && host_req_rdy_o && !host_req_op_i;
    assign free_push  = host_req_val_i && host_req_rdy_o &&  host_req_op_i;

    assign host_rsp_val_o = !resp_empty;
    assign rsp_pop        = host_rsp_val_o && host_rsp_rdy_i;

    falafel_fifo #(.W(DATA_W), .DEPTH(ALLOC_DEPTH)) u_alloc_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_i    (alloc_push),
        .din_i   (host_req_data_i),
        .rd_i    (alloc_fifo_read_i),
        .dout_o  (alloc_fifo_dout_o),
        .empty_o (alloc_fifo_empty_o),
        .full_o  (alloc_full)
    );

    falafel_fifo #(.W(DATA_W), .DEPTH(FREE_DEPTH)) u_free_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_i    (free_push),
        .din_i   (host_req_data_i),
        .rd_i    (free_fifo_read_i),
        .dout_o  (free_fifo_dout_o),
        .empty_o (free_fifo_empty_o),
        .full_o  (free_full)
    );

    falafel_fifo #(.W(DATA_W), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_i    (resp_fifo_write_i),
        .din_i   (resp_fifo_din_i),
        .rd_i    (host_rsp_rdy_i),
        .dout_o  (host_rsp_data_o),
        .empty_o (resp_empty),
        .full_o  (resp_fifo_full_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alloc_credits_o <= '0;
        end else begin
            case ({alloc_push, rsp_pop})
                2'b10:   alloc_credits_o <= alloc_credits_o + CREDIT_ONE;
                2'b01:   alloc_credits_o <= alloc_credits_o - CREDIT_ONE;
                default: alloc_credits_o <= alloc_credits_o;
            endcase
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 2'b00;
        end else begin
            if (resp_fifo_write_i && resp_fifo_full_o)
                err_o[0] <= 1'b1;
            if ((alloc_fifo_read_i && alloc_fifo_empty_o) ||
                (free_fifo_read_i && free_fifo_empty_o))
                err_o[1] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_falafel_frontend.sv
// Directed self-checking bench for falafel_frontend: walks the host, core and error
// scenarios step by step against hand-computed expectations.

module tb_falafel_frontend;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        host_req_val_i;
    logic        host_req_rdy_o;
    logic        host_req_op_i;
    logic [31:0] host_req_data_i;
    logic        host_rsp_val_o;
    logic        host_rsp_rdy_i;
    logic [31:0] host_rsp_data_o;
    logic        alloc_fifo_empty_o;
    logic        alloc_fifo_read_i;
    logic [31:0] alloc_fifo_dout_o;
    logic        free_fifo_empty_o;
    logic        free_fifo_read_i;
    logic [31:0] free_fifo_dout_o;
    logic        resp_fifo_full_o;
    logic        resp_fifo_write_i;
    logic [31:0] resp_fifo_din_i;
    logic [2:0]  alloc_credits_o;
    logic [1:0]  err_o;

    int vectors     = 0;
    int miscompares = 0;

    falafel_frontend dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .host_req_val_i     (host_req_val_i),
        .host_req_rdy_o     (host_req_rdy_o),
        .host_req_op_i      (host_req_op_i),
        .host_req_data_i    (host_req_data_i),
        .host_rsp_val_o     (host_rsp_val_o),
        .host_rsp_rdy_i     (host_rsp_rdy_i),
        .host_rsp_data_o    (host_rsp_data_o),
        .alloc_fifo_empty_o (alloc_fifo_empty_o),
        .alloc_fifo_read_i  (alloc_fifo_read_i),
        .alloc_fifo_dout_o  (alloc_fifo_dout_o),
        .free_fifo_empty_o  (free_fifo_empty_o),
        .free_fifo_read_i   (free_fifo_read_i),
        .free_fifo_dout_o   (free_fifo_dout_o),
        .resp_fifo_full_o   (resp_fifo_full_o),
        .resp_fifo_write_i  (resp_fifo_write_i),
        .resp_fifo_din_i    (resp_fifo_din_i),
        .alloc_credits_o    (alloc_credits_o),
        .err_o              (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic val, input logic op, input logic [31:0] data,
                                 input logic rsp_rdy, input logic aread, input logic fread,
                                 input logic rwrite, input logic [31:0] rdin);
        host_req_val_i    = val;
        host_req_op_i     = op;
        host_req_data_i   = data;
        host_rsp_rdy_i    = rsp_rdy;
        alloc_fifo_read_i = aread;
        free_fifo_read_i  = fread;
        resp_fifo_write_i = rwrite;
        resp_fifo_din_i   = rdin;
        #1;
    endtask

    task automatic idle(input logic op);
        applyStimulus(1'b0, op, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        idle(1'b0);
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        idle(1'b0);
        step();
        doReset();
        idle(1'b0);
        checkOutput("rst_alloc_empty", alloc_fifo_empty_o, 1);
        checkOutput("rst_free_empty", free_fifo_empty_o, 1);
        checkOutput("rst_resp_full", resp_fifo_full_o, 0);
        checkOutput("rst_rsp_val", host_rsp_val_o, 0);
        checkOutput("rst_credits", alloc_credits_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_rdy_alloc", host_req_rdy_o, 1);

        // Single alloc round trip
        applyStimulus(1, 0, 32'd24, 0, 0, 0, 0, 0);
        checkOutput("t1_rdy", host_req_rdy_o, 1);
        step();
        idle(0);
        checkOutput("t1_alloc_not_empty", alloc_fifo_empty_o, 0);
        checkOutput("t1_alloc_dout", alloc_fifo_dout_o, 32'd24);
        checkOutput("t1_credits1", alloc_credits_o, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("t1_dout_at_read", alloc_fifo_dout_o, 32'd24);
        step();
        idle(0);
        checkOutput("t1_alloc_empty", alloc_fifo_empty_o, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1008);
        step();
        idle(0);
        checkOutput("t1_rsp_val", host_rsp_val_o, 1);
        checkOutput("t1_rsp_data", host_rsp_data_o, 32'h1008);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        step();
        idle(0);
        checkOutput("t1_credits0", alloc_credits_o, 0);
        checkOutput("t1_rsp_val_clr", host_rsp_val_o, 0);

        // Credit limit blocks allocs but not frees
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 32'(i + 1), 0, 0, 0, 0, 0);
            step();
        end
        idle(0);
        checkOutput("t2_credits4", alloc_credits_o, 4);
        checkOutput("t2_rdy_alloc", host_req_rdy_o, 0);
        idle(1);
        checkOutput("t2_rdy_free", host_req_rdy_o, 1);
        applyStimulus(1, 1, 32'h2000, 0, 0, 0, 0, 0);
        step();
        idle(1);
        checkOutput("t2_free_not_empty", free_fifo_empty_o, 0);
        checkOutput("t2_free_dout", free_fifo_dout_o, 32'h2000);

        // Free FIFO full; same-cycle read still blocks the host
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1, 1, 32'h2000 + 32'(i), 0, 0, 0, 0, 0);
            step();
        end
        idle(1);
        checkOutput("t3_rdy_full", host_req_rdy_o, 0);
        applyStimulus(1, 1, 32'h2004, 0, 0, 1, 0, 0);
        checkOutput("t3_rdy_full_read", host_req_rdy_o, 0);
        checkOutput("t3_dout_head", free_fifo_dout_o, 32'h2000);
        step();
        idle(1);
        checkOutput("t3_rdy_after_read", host_req_rdy_o, 1);
        checkOutput("t3_dout_next", free_fifo_dout_o, 32'h2001);
        applyStimulus(1, 1, 32'h2004, 0, 0, 0, 0, 0);
        step();
        for (int i = 1; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
            checkOutput("t3_pop_a", free_fifo_dout_o, 32'h2000 + 32'(i));
            step();
        end
        idle(1);
        checkOutput("t3_free_empty_a", free_fifo_empty_o, 1);
        for (int i = 5; i < 8; i++) begin
            applyStimulus(1, 1, 32'h2000 + 32'(i), 0, 0, 0, 0, 0);
            step();
        end
        for (int i = 5; i < 8; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
            checkOutput("t3_pop_wrap", free_fifo_dout_o, 32'h2000 + 32'(i));
            step();
        end
        idle(1);
        checkOutput("t3_free_empty_b", free_fifo_empty_o, 1);

        // Response FIFO overflow
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 32'h10 + 32'(i), 0, 0, 0, 0, 0);
            step();
        end
        idle(0);
        checkOutput("t4_credits4", alloc_credits_o, 4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hA0 + 32'(i));
            step();
        end
        idle(0);
        checkOutput("t4_resp_full", resp_fifo_full_o, 1);
        checkOutput("t4_err_none", err_o, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hA4);
        step();
        idle(0);
        checkOutput("t4_err_overflow", err_o, 2'b01);
        checkOutput("t4_resp_still_full", resp_fifo_full_o, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
            checkOutput("t4_drain_val", host_rsp_val_o, 1);
            checkOutput("t4_drain_data", host_rsp_data_o, 32'hA0 + 32'(i));
            step();
        end
        idle(0);
        checkOutput("t4_drained", host_rsp_val_o, 0);
        checkOutput("t4_credits0", alloc_credits_o, 0);

        // Read of empty alloc FIFO
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
            checkOutput("t5_alloc_order", alloc_fifo_dout_o, 32'h10 + 32'(i));
            step();
        end
        idle(0);
        checkOutput("t5_alloc_empty", alloc_fifo_empty_o, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        step();
        idle(0);
        checkOutput("t5_err_underflow", err_o, 2'b11);
        checkOutput("t5_still_empty", alloc_fifo_empty_o, 1);
        applyStimulus(1, 0, 32'h40, 0, 0, 0, 0, 0);
        step();
        idle(0);
        checkOutput("t5_push_visible", alloc_fifo_empty_o, 0);
        checkOutput("t5_push_dout", alloc_fifo_dout_o, 32'h40);
        checkOutput("t5_credits1", alloc_credits_o, 1);

        // Reset mid-operation
        applyStimulus(1, 0, 32'h41, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h77);
        step();
        idle(0);
        checkOutput("t6_rsp_pending", host_rsp_val_o, 1);
        checkOutput("t6_credits2", alloc_credits_o, 2);
        doReset();
        idle(0);
        checkOutput("t6_alloc_empty", alloc_fifo_empty_o, 1);
        checkOutput("t6_free_empty", free_fifo_empty_o, 1);
        checkOutput("t6_credits0", alloc_credits_o, 0);
        checkOutput("t6_rsp_val", host_rsp_val_o, 0);
        checkOutput("t6_err", err_o, 0);
        checkOutput("t6_resp_full", resp_fifo_full_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
